// File: rtl/mod_clk_enable_gen_pkg.sv
// -----------------------------------------------------------------------------
// mod_clk_enable_gen_pkg
// Shared definitions for the fractional-N clock-enable generator.
//   cegen_state_e        : sequencing state of the generator (IDLE/SETTLE/LOCKED)
//   DEFAULT_LOCK_CYCLES  : default number of settle cycles before lock
//   inc_from_freq()      : elaboration-time helper that turns a reference and a
//                          target frequency into an NCO increment, rounded to
//                          the nearest step: inc = f_out / f_ref * 2^acc_w
// -----------------------------------------------------------------------------
package mod_clk_enable_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_LOCKED = 2'd2
   } cegen_state_e;

   localparam int DEFAULT_LOCK_CYCLES = 16;

   // Rounded increment for a target enable rate; only meant for constants.
   function automatic logic [63:0] inc_from_freq(
      input real f_ref_hz,
      input real f_out_hz,
      input int  acc_w
   );
      real scaled_s;
      scaled_s = (f_out_hz / f_ref_hz) * (2.0 ** acc_w);
      return 64'(longint'(scaled_s));
   endfunction

endpackage

// File: rtl/mod_clk_enable_gen_nco_channel.sv
// -----------------------------------------------------------------------------
// mod_nco_channel
// One phase-accumulator channel of the clock-enable generator.
//   clk      in   reference clock
//   rst_n    in   asynchronous active-low reset
//   clear    in   zero the accumulator and the strobe (reconfiguration)
//   run      in   advance the accumulator this cycle
//   load     in   capture load_inc as the new increment
//   load_inc in   new increment value
//   ce       out  registered carry of acc + inc, i.e. the enable strobe
// The accumulator is held whenever run is low; the strobe is only ever the
// carry of an actual advance, so it is 0 outside of run.
// -----------------------------------------------------------------------------
module mod_nco_channel #(
   parameter int               ACC_W     = 32,
   parameter logic [ACC_W-1:0] INC_RESET = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             run,
   input  logic             load,
   input  logic [ACC_W-1:0] load_inc,
   output logic             ce
);

   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] inc_r;
   logic             ce_r;
   logic [ACC_W:0]   sum_s;

   // Extended sum: the MSB is the wrap-around carry of the accumulator.
   always_comb begin
      sum_s = {1'b0, acc_r} + {1'b0, inc_r};
   end

   // Accumulator, increment and strobe registers; clear outranks run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= '0;
         inc_r <= INC_RESET;
         ce_r  <= 1'b0;
      end else begin
         if (load) begin
            inc_r <= load_inc;
         end
         if (clear) begin
            acc_r <= '0;
            ce_r  <= 1'b0;
         end else if (run) begin
            acc_r <= sum_s[ACC_W-1:0];
            ce_r  <= sum_s[ACC_W];
         end else begin
            ce_r  <= 1'b0;
         end
      end
   end

   assign ce = ce_r;

endmodule

// File: rtl/mod_clk_enable_gen.sv
// -----------------------------------------------------------------------------
// mod_clk_enable_gen
// Multi-channel fractional-N clock-enable generator. Each channel is an NCO
// whose carry is a one-cycle enable strobe at f_refclk * inc / 2^ACC_W.
//   refclk     in   single clock for all logic
//   rst_n      in   asynchronous active-low reset
//   cfg_valid  in   config write request
//   cfg_ready  out  config write can be accepted (SETTLE or LOCKED)
//   cfg_ch     in   target channel; values >= NUM_CH are consumed and dropped
//   cfg_inc    in   new increment for the target channel
//   outce      out  per-channel registered enable strobes
//   locked     out  strobes valid and phase-aligned
//   outtgl     out  per-channel toggle of outce (only with CEGEN_TOGGLE_OUT_EN)
// Optional feature macro: CEGEN_TOGGLE_OUT_EN.
// Every accepted write to a real channel clears all accumulators at once and
// restarts the settle count, so channel phases are deterministic afterwards.
// -----------------------------------------------------------------------------
module mod_clk_enable_gen
   import mod_clk_enable_gen_pkg::*;
#(
   parameter int                      NUM_CH      = 2,
   parameter int                      ACC_W       = 32,
   parameter int                      LOCK_CYCLES = DEFAULT_LOCK_CYCLES,
   parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = '0,
   localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   output logic [NUM_CH-1:0] outce,
   output logic              locked
`ifdef CEGEN_TOGGLE_OUT_EN
   ,
   output logic [NUM_CH-1:0] outtgl
`endif
);

   localparam int              CNT_W    = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   cegen_state_e      state_r;
   cegen_state_e      state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic              cfg_ready_r;
   logic              locked_r;
   logic              accept_s;
   logic              ch_ok_s;
   logic              reconf_s;
   logic              run_s;
   logic [NUM_CH-1:0] load_s;

   // Config handshake decode; out-of-range channels are accepted but inert.
   always_comb begin
      accept_s = cfg_valid & cfg_ready_r;
      ch_ok_s  = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
      reconf_s = accept_s & ch_ok_s;
      run_s    = (state_r == ST_LOCKED);
   end

   // Per-channel increment load strobes.
   always_comb begin
      load_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         load_s[i] = reconf_s & (cfg_ch == CH_W'(i));
      end
   end

   // Next-state and settle-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_SETTLE;
            cnt_nxt_s   = '0;
         end
         ST_SETTLE: begin
            if (reconf_s) begin
               cnt_nxt_s = '0;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_LOCKED;
               cnt_nxt_s   = '0;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_LOCKED: begin
            if (reconf_s) begin
               state_nxt_s = ST_SETTLE;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = ST_LOCKED;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // State and settle-counter registers.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Status outputs are registered from the next state so they change on the
   // same edge as the state itself.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ready_r <= 1'b0;
         locked_r    <= 1'b0;
      end else begin
         cfg_ready_r <= (state_nxt_s != ST_IDLE);
         locked_r    <= (state_nxt_s == ST_LOCKED);
      end
   end

   assign cfg_ready = cfg_ready_r;
   assign locked    = locked_r;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      mod_nco_channel #(
         .ACC_W     (ACC_W),
         .INC_RESET (INC_INIT[g*ACC_W +: ACC_W])
      ) u_nco (
         .clk      (refclk),
         .rst_n    (rst_n),
         .clear    (reconf_s),
         .run      (run_s),
         .load     (load_s[g]),
         .load_inc (cfg_inc),
         .ce       (outce[g])
      );
   end

`ifdef CEGEN_TOGGLE_OUT_EN
   logic [NUM_CH-1:0] tgl_r;

   // Square wave at f_ce/2: flip on every strobe, restart at reconfiguration.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         tgl_r <= '0;
      end else if (reconf_s) begin
         tgl_r <= '0;
      end else begin
         tgl_r <= tgl_r ^ outce;
      end
   end

   assign outtgl = tgl_r;
`endif

endmodule
